// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two caches, the unified memory and mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the cache/memory side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  // Cache requests
  logic              icache_MemRead;
  logic [ADDR_W-1:0] icache_mem_addr;
  logic              dcache_MemRead;
  logic              dcache_MemWrite;
  logic [ADDR_W-1:0] dcache_mem_addr;
  logic [DATA_W-1:0] dcache_mem_write_data;
  // Memory read return
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data_out;
  // Arbiter responses to the caches
  logic              icache_grant;
  logic              dcache_grant;
  logic              dcache_write_ack;
  logic              icache_MemDataValid;
  logic              dcache_MemDataValid;
  logic [DATA_W-1:0] mem_read_data;
  // Arbiter request to the memory
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;

  modport slave (
    input  icache_MemRead, icache_mem_addr, dcache_MemRead, dcache_MemWrite,
    input  dcache_mem_addr, dcache_mem_write_data, mem_data_valid, mem_data_out,
    output icache_grant, dcache_grant, dcache_write_ack, icache_MemDataValid,
    output dcache_MemDataValid, mem_read_data, mem_enable, mem_wr, mem_addr, mem_data_in
  );

  modport master (
    output icache_MemRead, icache_mem_addr, dcache_MemRead, dcache_MemWrite,
    output dcache_mem_addr, dcache_mem_write_data, mem_data_valid, mem_data_out,
    input  icache_grant, dcache_grant, dcache_write_ack, icache_MemDataValid,
    input  dcache_MemDataValid, mem_read_data, mem_enable, mem_wr, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory between the I-cache fill, D-cache fill and
// D-cache write-through paths. Fill bursts are granted whole to one cache; in-flight reads
// are counted so each returning beat is routed to the cache that issued it.
// Optional macro ARB_ROUND_ROBIN_EN: alternate fill priority using a last-served flop
// (D writes always keep absolute priority). Undefined: fixed D-over-I fill priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDrain} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  localparam logic [CNT_W-1:0] MaxOutstanding = CNT_W'(MEM_LATENCY);

  state_e            r_state, w_state_next;
  owner_e            r_owner, w_owner_next;
  logic [CNT_W-1:0]  r_outstanding, w_outstanding_next;

  logic              w_owner_read;
  logic [ADDR_W-1:0] w_owner_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_fill;
  logic              w_beat;
  logic              w_room;
  logic              w_issue;
  logic              w_write;
  logic              w_pick_d;

  // Writes are gated by reset so nothing reaches memory while rst is low.
  assign w_write   = bus.dcache_MemWrite & rst;
  assign w_wr_data = bus.dcache_mem_write_data;
  assign w_fill    = (r_state == StIFill) || (r_state == StDFill);
  // A beat only counts while something is in flight; otherwise it is dropped.
  assign w_beat    = bus.mem_data_valid && (r_outstanding != '0);
  // A beat retiring this cycle frees a slot, so a full pipe can still stream.
  assign w_room    = (r_outstanding < MaxOutstanding) || w_beat;
  assign w_issue   = w_fill && w_owner_read && w_room;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e r_last_served;

  // Remember which cache won the most recent fill so the other wins a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_served <= OwnI;
    end else if ((r_state == StIdle) && (w_owner_next != OwnNone)) begin
      r_last_served <= w_owner_next;
    end
  end

  assign w_pick_d = bus.dcache_MemRead && (!bus.icache_MemRead || (r_last_served == OwnI));
`else
  assign w_pick_d = bus.dcache_MemRead;
`endif

  // Select the current owner's read request and address.
  always_comb begin
    w_owner_read = 1'b0;
    w_owner_addr = '0;
    case (r_owner)
      OwnI: begin
        w_owner_read = bus.icache_MemRead;
        w_owner_addr = bus.icache_mem_addr;
      end
      OwnD: begin
        w_owner_read = bus.dcache_MemRead;
        w_owner_addr = bus.dcache_mem_addr;
      end
      default: ;
    endcase
  end

  // Outstanding-read count: +1 per issue, -1 per counted beat.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_issue && !w_beat) begin
      w_outstanding_next = r_outstanding + CNT_W'(1);
    end else if (!w_issue && w_beat) begin
      w_outstanding_next = r_outstanding - CNT_W'(1);
    end
  end

  // Next-state, owner and memory-side outputs.
  always_comb begin
    w_state_next         = r_state;
    w_owner_next         = r_owner;
    bus.mem_enable       = 1'b0;
    bus.mem_wr           = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_data_in      = '0;
    bus.dcache_write_ack = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_write) begin
          bus.mem_enable       = 1'b1;
          bus.mem_wr           = 1'b1;
          bus.mem_addr         = bus.dcache_mem_addr;
          bus.mem_data_in      = w_wr_data;
          bus.dcache_write_ack = 1'b1;
        end else if (w_pick_d) begin
          w_state_next = StDFill;
          w_owner_next = OwnD;
        end else if (bus.icache_MemRead) begin
          w_state_next = StIFill;
          w_owner_next = OwnI;
        end
      end
      StIFill, StDFill: begin
        bus.mem_enable = w_issue;
        bus.mem_addr   = w_owner_addr;
        if (!w_owner_read) begin
          if (w_outstanding_next == '0) begin
            w_state_next = StIdle;
            w_owner_next = OwnNone;
          end else begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        if (w_outstanding_next == '0) begin
          w_state_next = StIdle;
          w_owner_next = OwnNone;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_owner_next = OwnNone;
      end
    endcase
  end

  // State, owner and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_owner       <= OwnNone;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_next;
      r_owner       <= w_owner_next;
      r_outstanding <= w_outstanding_next;
    end
  end

  // Grants follow the registered owner, which is set for the whole fill and drain.
  assign bus.icache_grant        = (r_owner == OwnI);
  assign bus.dcache_grant        = (r_owner == OwnD);
  assign bus.icache_MemDataValid = w_beat && (r_owner == OwnI);
  assign bus.dcache_MemDataValid = w_beat && (r_owner == OwnD);
  assign bus.mem_read_data       = bus.mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a fixed-latency
// memory model that can be switched off to drive mem_data_valid by hand.
module tb_mem_arbiter;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) u_bus ();

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(LAT), .CNT_W(3)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (u_bus)
  );

  // Memory model: a read issued in cycle t returns valid data (addr ^ A5A5) in cycle t+LAT.
  logic           mem_auto  = 1'b0;
  logic           man_valid = 1'b0;
  logic [15:0]    man_data  = 16'h0;
  logic [LAT-1:0] pipe_v    = '0;
  logic [15:0]    pipe_d [LAT] = '{default: 16'h0};

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], u_bus.mem_enable & ~u_bus.mem_wr};
    pipe_d[0] <= u_bus.mem_addr ^ 16'hA5A5;
    for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign u_bus.mem_data_valid = mem_auto ? pipe_v[LAT-1] : man_valid;
  assign u_bus.mem_data_out   = mem_auto ? pipe_d[LAT-1] : man_data;

  // Event monitor
  int          n_rd = 0, n_ib = 0, n_db = 0, cyc = 0, last_issue = 0, last_ibeat = 0;
  logic [15:0] last_idata = 16'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u_bus.mem_enable && !u_bus.mem_wr) begin
      n_rd       <= n_rd + 1;
      last_issue <= cyc;
    end
    if (u_bus.icache_MemDataValid) begin
      n_ib       <= n_ib + 1;
      last_ibeat <= cyc;
      last_idata <= u_bus.mem_read_data;
    end
    if (u_bus.dcache_MemDataValid) n_db <= n_db + 1;
  end

  function automatic logic [6:0] all_outs();
    return {u_bus.icache_grant, u_bus.dcache_grant, u_bus.dcache_write_ack,
            u_bus.icache_MemDataValid, u_bus.dcache_MemDataValid, u_bus.mem_enable, u_bus.mem_wr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_bus.icache_MemRead        = 1'b0;
    u_bus.icache_mem_addr       = 16'h0;
    u_bus.dcache_MemRead        = 1'b0;
    u_bus.dcache_MemWrite       = 1'b0;
    u_bus.dcache_mem_addr       = 16'h0;
    u_bus.dcache_mem_write_data = 16'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_bus.icache_MemRead  = 1'b1;
    u_bus.dcache_MemRead  = 1'b1;
    u_bus.dcache_MemWrite = 1'b1;
    man_valid = 1'b1;
    man_data  = 16'h1234;
    repeat (2) step();
    tests++;
    if (all_outs() !== 7'b0) begin
      fails++; $display("FAIL reset_outs: got %b want %b", all_outs(), 7'b0);
    end
    tests++;
    if (u_bus.mem_read_data !== 16'h1234) begin
      fails++; $display("FAIL reset_rdata: got %h want %h", u_bus.mem_read_data, 16'h1234);
    end
    idle_inputs();
    man_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (all_outs() !== 7'b0) begin
      fails++; $display("FAIL post_reset_idle: got %b want %b", all_outs(), 7'b0);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_icache_fill();
    int b_rd, b_ib, b_db;
    b_rd = n_rd; b_ib = n_ib; b_db = n_db;
    u_bus.icache_MemRead  = 1'b1;
    u_bus.icache_mem_addr = 16'h0100;
    #1;
    tests++;
    if ({u_bus.icache_grant, u_bus.mem_enable} !== 2'b00) begin
      fails++; $display("FAIL ifill_c0: got %b want %b", {u_bus.icache_grant, u_bus.mem_enable}, 2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_a;
      exp_a = 16'h0100 + 16'(2 * i);
      step();
      u_bus.icache_mem_addr = exp_a;
      #1;
      tests++;
      if ({u_bus.icache_grant, u_bus.mem_enable, u_bus.mem_wr, u_bus.mem_addr} !== {3'b110, exp_a}) begin
        fails++; $display("FAIL ifill_issue%0d: got %b%b%b %h want 110 %h", i, u_bus.icache_grant,
                          u_bus.mem_enable, u_bus.mem_wr, u_bus.mem_addr, exp_a);
      end
    end
    step();
    u_bus.icache_MemRead = 1'b0;
    repeat (3) step();
    tests++;
    if (u_bus.icache_grant !== 1'b1) begin
      fails++; $display("FAIL ifill_drain_grant: got %b want 1", u_bus.icache_grant);
    end
    step();
    tests++;
    if (u_bus.icache_grant !== 1'b0) begin
      fails++; $display("FAIL ifill_end_grant: got %b want 0", u_bus.icache_grant);
    end
    tests++;
    if ({n_rd - b_rd, n_ib - b_ib, n_db - b_db} !== {32'd8, 32'd8, 32'd0}) begin
      fails++; $display("FAIL ifill_counts: got rd=%0d ib=%0d db=%0d want 8 8 0",
                        n_rd - b_rd, n_ib - b_ib, n_db - b_db);
    end
    tests++;
    if (last_ibeat - last_issue !== LAT) begin
      fails++; $display("FAIL ifill_latency: got %0d want %0d", last_ibeat - last_issue, LAT);
    end
    tests++;
    if (last_idata !== (16'h010E ^ 16'hA5A5)) begin
      fails++; $display("FAIL ifill_last_data: got %h want %h", last_idata, 16'h010E ^ 16'hA5A5);
    end
  endtask

  task automatic test_priority();
    logic exp_d;
    int   b_ib, b_db;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = 1'b0;
`else
    exp_d = 1'b1;
`endif
    // A lone D fill first, so D is the last-served cache.
    u_bus.dcache_MemRead  = 1'b1;
    u_bus.dcache_mem_addr = 16'h3000;
    step();
    tests++;
    if (u_bus.dcache_grant !== 1'b1) begin
      fails++; $display("FAIL lone_d_grant: got %b want 1", u_bus.dcache_grant);
    end
    step();
    u_bus.dcache_MemRead = 1'b0;
    repeat (4) step();
    tests++;
    if (u_bus.dcache_grant !== 1'b0) begin
      fails++; $display("FAIL lone_d_end: got %b want 0", u_bus.dcache_grant);
    end
    // Both caches request together.
    b_ib = n_ib; b_db = n_db;
    u_bus.icache_MemRead  = 1'b1;
    u_bus.icache_mem_addr = 16'h0200;
    u_bus.dcache_MemRead  = 1'b1;
    u_bus.dcache_mem_addr = 16'h3100;
    step();
    tests++;
    if ({u_bus.icache_grant, u_bus.dcache_grant, u_bus.mem_addr} !==
        (exp_d ? {2'b01, 16'h3100} : {2'b10, 16'h0200})) begin
      fails++; $display("FAIL prio_first: got %b%b %h want d_first=%b", u_bus.icache_grant,
                        u_bus.dcache_grant, u_bus.mem_addr, exp_d);
    end
    step();
    step();
    if (exp_d) u_bus.dcache_MemRead = 1'b0;
    else       u_bus.icache_MemRead = 1'b0;
    repeat (3) step();
    tests++;
    if ({u_bus.icache_grant, u_bus.dcache_grant} !== (exp_d ? 2'b01 : 2'b10)) begin
      fails++; $display("FAIL prio_drain_end: got %b%b", u_bus.icache_grant, u_bus.dcache_grant);
    end
    step();
    tests++;
    if ({u_bus.icache_grant, u_bus.dcache_grant} !== 2'b00) begin
      fails++; $display("FAIL prio_gap_idle: got %b%b want 00", u_bus.icache_grant, u_bus.dcache_grant);
    end
    tests++;
    if ({n_ib - b_ib, n_db - b_db} !== (exp_d ? {32'd0, 32'd2} : {32'd2, 32'd0})) begin
      fails++; $display("FAIL prio_routing: got ib=%0d db=%0d", n_ib - b_ib, n_db - b_db);
    end
    step();
    tests++;
    if ({u_bus.icache_grant, u_bus.dcache_grant} !== (exp_d ? 2'b10 : 2'b01)) begin
      fails++; $display("FAIL prio_second: got %b%b", u_bus.icache_grant, u_bus.dcache_grant);
    end
    idle_inputs();
    step();
    tests++;
    if ({u_bus.icache_grant, u_bus.dcache_grant} !== 2'b00) begin
      fails++; $display("FAIL prio_final_idle: got %b%b want 00", u_bus.icache_grant, u_bus.dcache_grant);
    end
  endtask

  task automatic test_write_during_fill();
    u_bus.icache_MemRead  = 1'b1;
    u_bus.icache_mem_addr = 16'h0400;
    step();
    step();
    u_bus.icache_mem_addr       = 16'h0402;
    u_bus.dcache_MemWrite       = 1'b1;
    u_bus.dcache_mem_addr       = 16'h2000;
    u_bus.dcache_mem_write_data = 16'hBEEF;
    #1;
    tests++;
    if ({u_bus.dcache_write_ack, u_bus.mem_wr, u_bus.mem_addr} !== {2'b00, 16'h0402}) begin
      fails++; $display("FAIL wr_in_fill: got ack=%b wr=%b addr=%h want 0 0 0402",
                        u_bus.dcache_write_ack, u_bus.mem_wr, u_bus.mem_addr);
    end
    step();
    u_bus.icache_MemRead = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      if (c > 3) step();
      #1;
      tests++;
      if (u_bus.dcache_write_ack !== 1'b0) begin
        fails++; $display("FAIL wr_wait_c%0d: got ack=%b want 0", c, u_bus.dcache_write_ack);
      end
    end
    step();
    tests++;
    if ({u_bus.dcache_write_ack, u_bus.mem_enable, u_bus.mem_wr, u_bus.icache_grant,
         u_bus.mem_addr, u_bus.mem_data_in} !== {4'b1110, 16'h2000, 16'hBEEF}) begin
      fails++; $display("FAIL wr_first_idle: got ack=%b en=%b wr=%b ig=%b addr=%h data=%h",
                        u_bus.dcache_write_ack, u_bus.mem_enable, u_bus.mem_wr,
                        u_bus.icache_grant, u_bus.mem_addr, u_bus.mem_data_in);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if ({u_bus.dcache_write_ack, u_bus.mem_enable} !== 2'b00) begin
      fails++; $display("FAIL wr_release: got %b%b want 00", u_bus.dcache_write_ack, u_bus.mem_enable);
    end
  endtask

  task automatic test_drain_stray();
    int b_ib, b_db;
    b_ib = n_ib; b_db = n_db;
    u_bus.dcache_MemRead  = 1'b1;
    u_bus.dcache_mem_addr = 16'h5000;
    for (int i = 0; i < 3; i++) begin
      step();
      u_bus.dcache_mem_addr = 16'h5000 + 16'(2 * i);
    end
    step();
    u_bus.dcache_MemRead = 1'b0;
    #1;
    tests++;
    if ({u_bus.dcache_grant, u_bus.mem_enable} !== 2'b10) begin
      fails++; $display("FAIL drain_enter: got %b%b want 10", u_bus.dcache_grant, u_bus.mem_enable);
    end
    step();
    u_bus.dcache_MemRead = 1'b1;
    #1;
    tests++;
    if (u_bus.mem_enable !== 1'b0) begin
      fails++; $display("FAIL drain_no_issue: got %b want 0", u_bus.mem_enable);
    end
    u_bus.dcache_MemRead = 1'b0;
    step();
    step();
    tests++;
    if ({u_bus.dcache_grant, u_bus.dcache_MemDataValid} !== 2'b11) begin
      fails++; $display("FAIL drain_third_beat: got %b%b want 11", u_bus.dcache_grant,
                        u_bus.dcache_MemDataValid);
    end
    step();
    tests++;
    if ({u_bus.dcache_grant, n_db - b_db, n_ib - b_ib} !== {1'b0, 32'd3, 32'd0}) begin
      fails++; $display("FAIL drain_done: got dg=%b db=%0d ib=%0d want 0 3 0",
                        u_bus.dcache_grant, n_db - b_db, n_ib - b_ib);
    end
    mem_auto  = 1'b0;
    man_valid = 1'b1;
    man_data  = 16'h7777;
    #1;
    tests++;
    if ({u_bus.icache_MemDataValid, u_bus.dcache_MemDataValid, u_bus.mem_read_data} !==
        {2'b00, 16'h7777}) begin
      fails++; $display("FAIL stray_beat: got iv=%b dv=%b data=%h want 0 0 7777",
                        u_bus.icache_MemDataValid, u_bus.dcache_MemDataValid, u_bus.mem_read_data);
    end
    step();
    man_valid = 1'b0;
    mem_auto  = 1'b1;
  endtask

  task automatic test_reset_mid_fill();
    int b_ib;
    u_bus.dcache_MemRead  = 1'b1;
    u_bus.dcache_mem_addr = 16'h6000;
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (all_outs() !== 7'b0) begin
      fails++; $display("FAIL rst_mid_outs: got %b want %b", all_outs(), 7'b0);
    end
    u_bus.dcache_MemRead = 1'b0;
    step();
    u_bus.icache_MemRead  = 1'b1;
    u_bus.icache_mem_addr = 16'h0700;
    rst_n = 1'b1;
    step();
    u_bus.icache_MemRead = 1'b0;
    #1;
    // A leftover beat from the abandoned burst arrives now; the cleared count must drop it.
    tests++;
    if ({u_bus.icache_grant, u_bus.icache_MemDataValid, u_bus.dcache_MemDataValid} !== 3'b100) begin
      fails++; $display("FAIL rst_stale_beat: got %b%b%b want 100", u_bus.icache_grant,
                        u_bus.icache_MemDataValid, u_bus.dcache_MemDataValid);
    end
    step();
    step();
    b_ib = n_ib;
    u_bus.icache_MemRead  = 1'b1;
    u_bus.icache_mem_addr = 16'h0710;
    step();
    tests++;
    if ({u_bus.icache_grant, u_bus.mem_enable, u_bus.mem_addr} !== {2'b11, 16'h0710}) begin
      fails++; $display("FAIL rst_regrant: got ig=%b en=%b addr=%h want 1 1 0710",
                        u_bus.icache_grant, u_bus.mem_enable, u_bus.mem_addr);
    end
    step();
    u_bus.icache_MemRead = 1'b0;
    repeat (4) step();
    tests++;
    if ({u_bus.icache_grant, n_ib - b_ib} !== {1'b0, 32'd1}) begin
      fails++; $display("FAIL rst_refill_done: got ig=%b ib=%0d want 0 1", u_bus.icache_grant, n_ib - b_ib);
    end
  endtask

  task automatic test_saturation();
    int b_rd;
    mem_auto  = 1'b0;
    man_valid = 1'b0;
    b_rd = n_rd;
    u_bus.icache_MemRead  = 1'b1;
    u_bus.icache_mem_addr = 16'h0800;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 4 || c == 5 || c == 10) begin
        tests++;
        if ({u_bus.icache_grant, u_bus.mem_enable} !== {1'b1, (c == 4)}) begin
          fails++; $display("FAIL sat_c%0d: got %b%b want 1%b", c, u_bus.icache_grant,
                            u_bus.mem_enable, c == 4);
        end
      end
    end
    step();
    u_bus.icache_MemRead = 1'b0;
    #1;
    tests++;
    if (n_rd - b_rd !== LAT) begin
      fails++; $display("FAIL sat_reads: got %0d want %0d", n_rd - b_rd, LAT);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      man_valid = 1'b1;
      man_data  = 16'(k);
      #1;
      tests++;
      if ({u_bus.icache_grant, u_bus.icache_MemDataValid, u_bus.mem_enable} !== 3'b110) begin
        fails++; $display("FAIL sat_beat%0d: got %b%b%b want 110", k, u_bus.icache_grant,
                          u_bus.icache_MemDataValid, u_bus.mem_enable);
      end
    end
    step();
    man_valid = 1'b0;
    #1;
    tests++;
    if (u_bus.icache_grant !== 1'b0) begin
      fails++; $display("FAIL sat_end: got %b want 0", u_bus.icache_grant);
    end
    mem_auto = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_icache_fill();
    step();
    test_priority();
    step();
    test_write_during_fill();
    step();
    test_drain_stray();
    step();
    test_reset_mid_fill();
    step();
    test_saturation();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle unified memory between the I-cache and D-cache fill FSMs and the D-cache write-through path.
- Grants whole fill bursts to one cache at a time.
- Tracks in-flight reads and routes each returning beat to the cache that issued it.
- Sits between the two cache instances and the memory module in the top-level processor.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- MEM_LATENCY, 4, cycles from a read issue to its data-valid beat.
- CNT_W, 3, width of the outstanding-read counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- icache_MemRead  in  1  I-cache fill read request, one beat per cycle.
- icache_mem_addr  in  ADDR_W  I-cache read address.
- dcache_MemRead  in  1  D-cache fill read request.
- dcache_MemWrite  in  1  D-cache write-through request.
- dcache_mem_addr  in  ADDR_W  D-cache read/write address.
- dcache_mem_write_data  in  DATA_W  D-cache write data.
- mem_data_valid  in  1  memory read data valid.
- mem_data_out  in  DATA_W  memory read data.
- icache_grant  out  1  I-cache owns the memory.
- dcache_grant  out  1  D-cache owns the memory for a fill.
- dcache_write_ack  out  1  D-cache write accepted this cycle.
- icache_MemDataValid  out  1  beat for the I-cache.
- dcache_MemDataValid  out  1  beat for the D-cache.
- mem_read_data  out  DATA_W  mem_data_out forwarded to both caches.
- mem_enable  out  1  memory access enable.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  memory write data.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state = IDLE, outstanding counter = 0;
  - all grants, acks, valids, mem_enable and mem_wr = 0.
- Reset mid-burst abandons the burst. Caches are reset by the same rst.
- States are IDLE, I_FILL, D_FILL, DRAIN. Owner register: NONE, I or D.
- IDLE:
  - dcache_MemWrite has top priority. Drive mem_enable=1, mem_wr=1, mem_addr=dcache_mem_addr, mem_data_in=dcache_mem_write_data, and dcache_write_ack=1 combinationally. Stay in IDLE.
  - Otherwise, if dcache_MemRead: go to D_FILL next cycle, owner=D.
  - Otherwise, if icache_MemRead: go to I_FILL next cycle, owner=I.
  - No memory read is issued from IDLE. The grant appears one cycle after the request.
- I_FILL / D_FILL:
  - The owner's grant is registered high.
  - mem_enable = owner MemRead, mem_wr=0, mem_addr = owner address.
  - The non-owner's requests are ignored. A D-cache write arriving during I_FILL waits (no ack) until IDLE.
  - When the owner's MemRead drops: go to IDLE if outstanding==0 (counting this cycle's update), else go to DRAIN.
- DRAIN:
  - Grant stays high and mem_enable=0.
  - Go to IDLE when outstanding reaches 0.
- Outstanding counter:
  - +1 on each read issue, -1 on each mem_data_valid; both in the same cycle leaves it unchanged.
  - Saturates at MEM_LATENCY: no increment, and the read is suppressed (mem_enable=0) that cycle.
  - Never decrements below 0.
- Data routing:
  - icache_MemDataValid = mem_data_valid & owner==I & outstanding>0; dcache_MemDataValid likewise for D.
  - mem_data_valid with outstanding==0 is dropped and routed to neither cache.
- Back-to-back bursts: after returning to IDLE, arbitration restarts. Fixed priority is D over I.
- mem_read_data = mem_data_out at all times, ungated.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last-served flop (reset = I) sets fill priority. When both caches request a read in IDLE, the cache not last served wins.
  - D writes keep absolute priority.
- Undefined: fixed D-over-I fill priority. No last-served flop.

Test Plan:
- I-cache fill alone: icache_MemRead high 8 cycles at 0x0100..0x010E after grant.
  - icache_grant=1 on cycle 1.
  - 8 mem reads, 8 icache_MemDataValid beats, the last MEM_LATENCY cycles after the last issue.
  - Back to IDLE, grant=0.
- Simultaneous fill requests, fixed priority:
  - D gets dcache_grant first; I is granted one cycle after D's DRAIN ends.
  - Under ARB_ROUND_ROBIN_EN with last-served=D, I wins instead.
- D write 0xBEEF to 0x2000 during I_FILL:
  - No ack during the burst.
  - In the first IDLE cycle: mem_wr=1, mem_addr=0x2000, mem_data_in=0xBEEF, dcache_write_ack=1.
- Owner drops MemRead with 3 reads in flight:
  - State is DRAIN; 3 beats are routed to the owner only.
  - IDLE follows the third beat.
  - A stray mem_data_valid afterwards produces no valid on either cache.
- Assert rst low mid-D_FILL with 2 reads outstanding:
  - All outputs go to 0 immediately and the counter goes to 0.
  - After release, an I request is granted normally.
- Owner holds MemRead for 10 cycles with mem_data_valid held low:
  - Exactly MEM_LATENCY reads are issued, then mem_enable stays 0 until beats return.
